// File: rtl/elevator_pkg.sv
// Shared elevator constants and types used by the call-request front end.
package elevator_pkg;

  localparam int unsigned FLOOR_W = 3;
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = 3'd7;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam logic CALL_INSIDE = 1'b1;
  localparam logic CALL_HALL   = 1'b0;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

  typedef struct packed {
    logic [FLOOR_W-1:0] floor;
    logic               in_out;
    logic               dir;
  } call_t;

endpackage

// File: rtl/call_request_conditioner_debounce.sv
// Two-flop synchroniser plus counting debouncer; emits a one-cycle press pulse
// on each accepted rising level.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Registering the pulse here keeps it aligned with the stable toggle.
        stable <= ~stable;
        cnt    <= '0;
        press  <= ~stable;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/call_request_conditioner.sv
// Turns raw buttons and floor switches into single valid/ready call requests,
// counting every press that is rejected, out-prioritised or finds the slot full.
module call_request_conditioner
  import elevator_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned DROP_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              button_up,
  input  logic              button_down,
  input  logic              button_in,
  input  logic [5:0]        sw,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [2:0]        req_floor,
  output logic              req_in_out,
  output logic              req_dir,
  output logic [DROP_W-1:0] drop_count
);

  logic press_up;
  logic press_down;
  logic press_in;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk   (clk),
    .reset (reset),
    .raw   (button_up),
    .press (press_up)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .clk   (clk),
    .reset (reset),
    .raw   (button_down),
    .press (press_down)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_in (
    .clk   (clk),
    .reset (reset),
    .raw   (button_in),
    .press (press_in)
  );

  hold_state_e        state;
  hold_state_e        state_next;
  call_t              call;
  call_t              call_next;
  call_t              cand;
  logic               cand_hit;
  logic               reject;
  logic               occ_drop;
  logic               handshake;
  logic [1:0]         lost;
  logic [1:0]         incr;
  logic [DROP_W:0]    drop_sum;
  logic [DROP_W-1:0]  drop_next;
  logic [FLOOR_W-1:0] hall_floor;
  logic [FLOOR_W-1:0] cabin_floor;

  assign hall_floor  = sw[5:3];
  assign cabin_floor = sw[2:0];

  always_comb begin
    cand_hit   = 1'b0;
    reject     = 1'b0;
    lost       = 2'd0;
    cand       = '0;
    occ_drop   = 1'b0;
    state_next = state;
    call_next  = call;
    handshake  = (state == HOLD_FULL) && req_ready;

    if (press_in) begin
      cand_hit    = 1'b1;
      cand.floor  = cabin_floor;
      cand.in_out = CALL_INSIDE;
      cand.dir    = DIR_DOWN;
      lost        = {1'b0, press_up} + {1'b0, press_down};
    end else if (press_up) begin
      cand_hit    = 1'b1;
      cand.floor  = hall_floor;
      cand.in_out = CALL_HALL;
      cand.dir    = DIR_UP;
      lost        = {1'b0, press_down};
      reject      = (hall_floor == TOP_FLOOR);
    end else if (press_down) begin
      cand_hit    = 1'b1;
      cand.floor  = hall_floor;
      cand.in_out = CALL_HALL;
      cand.dir    = DIR_DOWN;
      reject      = (hall_floor == '0);
    end

    if (cand_hit && !reject) begin
      if ((state == HOLD_EMPTY) || handshake) begin
        state_next = HOLD_FULL;
        call_next  = cand;
      end else begin
        occ_drop = 1'b1;
      end
    end else if (handshake) begin
      state_next = HOLD_EMPTY;
    end

    // Same-edge drop sources are summed first so saturation is applied once.
    incr      = lost + {1'b0, reject} + {1'b0, occ_drop};
    drop_sum  = {1'b0, drop_count} + (DROP_W+1)'(incr);
    drop_next = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HOLD_EMPTY;
      call       <= '0;
      drop_count <= '0;
    end else begin
      state      <= state_next;
      call       <= call_next;
      drop_count <= drop_next;
    end
  end

  assign req_valid  = (state == HOLD_FULL);
  assign req_floor  = call.floor;
  assign req_in_out = call.in_out;
  assign req_dir    = call.dir;

endmodule

// File: tb/tb_call_request_conditioner.sv
// Directed bench for call_request_conditioner with DEBOUNCE_CYCLES=4.
module tb_call_request_conditioner;

  localparam int unsigned DC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       button_up;
  logic       button_down;
  logic       button_in;
  logic [5:0] sw;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_floor;
  logic       req_in_out;
  logic       req_dir;
  logic [7:0] drop_count;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  call_request_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .DROP_W         (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .button_up  (button_up),
    .button_down(button_down),
    .button_in  (button_in),
    .sw         (sw),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_floor  (req_floor),
    .req_in_out (req_in_out),
    .req_dir    (req_dir),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] btn;   // {in, up, down}
    logic [5:0] sw;
    logic       exp_valid;
    logic [2:0] exp_floor;
    logic       exp_in_out;
    logic       exp_dir;
    logic [7:0] exp_drop;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [2:0] b, input logic [2:0] hall, input logic [2:0] cab,
                              input logic v, input logic [2:0] f, input logic io,
                              input logic d, input logic [7:0] dr);
    vec_t r;
    r.btn        = b;
    r.sw         = {hall, cab};
    r.exp_valid  = v;
    r.exp_floor  = f;
    r.exp_in_out = io;
    r.exp_dir    = d;
    r.exp_drop   = dr;
    return r;
  endfunction

  function automatic logic [31:0] pk(input logic v, input logic [2:0] f, input logic io,
                                     input logic d, input logic [7:0] dr);
    return {18'd0, v, f, io, d, dr};
  endfunction

  function automatic logic [31:0] cur();
    return pk(req_valid, req_floor, req_in_out, req_dir, drop_count);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input logic [2:0] b);
    {button_in, button_up, button_down} = b;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_ready = 1'b0;
    set_btn(3'b000);
    tick(2);
    check("reset_outputs", cur(), pk(1'b0, 3'd0, 1'b0, 1'b0, 8'd0));
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    sw    = '0;
    req_ready = 1'b0;
    set_btn(3'b000);

    vecs[0]  = mk(3'b100, 3'd0, 3'd5, 1'b1, 3'd5, 1'b1, 1'b0, 8'd0);
    vecs[1]  = mk(3'b010, 3'd3, 3'd0, 1'b1, 3'd3, 1'b0, 1'b1, 8'd0);
    vecs[2]  = mk(3'b001, 3'd4, 3'd2, 1'b1, 3'd4, 1'b0, 1'b0, 8'd0);
    vecs[3]  = mk(3'b010, 3'd7, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 8'd1);
    vecs[4]  = mk(3'b001, 3'd0, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0, 8'd1);
    vecs[5]  = mk(3'b101, 3'd3, 3'd6, 1'b1, 3'd6, 1'b1, 1'b0, 8'd1);
    vecs[6]  = mk(3'b011, 3'd2, 3'd0, 1'b1, 3'd2, 1'b0, 1'b1, 8'd1);
    vecs[7]  = mk(3'b111, 3'd7, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0, 8'd2);
    vecs[8]  = mk(3'b011, 3'd7, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 8'd2);
    vecs[9]  = mk(3'b001, 3'd7, 3'd1, 1'b1, 3'd7, 1'b0, 1'b0, 8'd0);
    vecs[10] = mk(3'b010, 3'd0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1, 8'd0);
    vecs[11] = mk(3'b110, 3'd6, 3'd4, 1'b1, 3'd4, 1'b1, 1'b0, 8'd1);

    tick(2);
    check("power_on_reset", cur(), pk(1'b0, 3'd0, 1'b0, 1'b0, 8'd0));

    // Single press patterns: nothing visible after edge N+5, result after edge N+6.
    for (int i = 0; i < 12; i++) begin
      do_reset();
      sw = vecs[i].sw;
      set_btn(vecs[i].btn);
      tick(6);
      check($sformatf("vec%0d_early", i), {23'd0, req_valid, drop_count}, 32'd0);
      tick(1);
      check($sformatf("vec%0d_result", i), cur(),
            pk(vecs[i].exp_valid, vecs[i].exp_floor, vecs[i].exp_in_out,
               vecs[i].exp_dir, vecs[i].exp_drop));
      set_btn(3'b000);
      tick(10);
    end

    // Clean cabin press held pending, then cleared by a one-cycle ready.
    do_reset();
    sw = {3'd0, 3'd5};
    set_btn(3'b100);
    tick(7);
    check("clean_load", cur(), pk(1'b1, 3'd5, 1'b1, 1'b0, 8'd0));
    tick(10);
    check("clean_hold", cur(), pk(1'b1, 3'd5, 1'b1, 1'b0, 8'd0));
    req_ready = 1'b1;
    tick(1);
    req_ready = 1'b0;
    check("clean_accept", {31'd0, req_valid}, 32'd0);
    set_btn(3'b000);
    tick(10);

    // Bounce on button_up before a steady high.
    do_reset();
    sw = {3'd2, 3'd0};
    button_up = 1'b1; tick(1);
    button_up = 1'b0; tick(1);
    button_up = 1'b1; tick(1);
    button_up = 1'b0; tick(1);
    button_up = 1'b1;
    tick(6);
    check("bounce_early", {31'd0, req_valid}, 32'd0);
    tick(1);
    check("bounce_load", cur(), pk(1'b1, 3'd2, 1'b0, 1'b1, 8'd0));
    tick(20);
    check("bounce_single", cur(), pk(1'b1, 3'd2, 1'b0, 1'b1, 8'd0));
    set_btn(3'b000);
    tick(10);

    // Invalid hall calls accumulate.
    do_reset();
    sw = {3'd7, 3'd0};
    set_btn(3'b010);
    tick(7);
    check("invalid_up_top", cur(), pk(1'b0, 3'd0, 1'b0, 1'b0, 8'd1));
    set_btn(3'b000);
    tick(10);
    sw = {3'd0, 3'd0};
    set_btn(3'b001);
    tick(7);
    check("invalid_down_ground", cur(), pk(1'b0, 3'd0, 1'b0, 1'b0, 8'd2));
    set_btn(3'b000);
    tick(10);

    // Occupancy: drop while full, then replace on the handshake edge.
    do_reset();
    sw = {3'd3, 3'd5};
    set_btn(3'b100);
    tick(7);
    check("occ_first", cur(), pk(1'b1, 3'd5, 1'b1, 1'b0, 8'd0));
    set_btn(3'b000);
    tick(10);
    set_btn(3'b010);
    tick(7);
    check("occ_dropped", cur(), pk(1'b1, 3'd5, 1'b1, 1'b0, 8'd1));
    set_btn(3'b000);
    tick(10);
    sw = {3'd4, 3'd5};
    set_btn(3'b001);
    tick(6);
    req_ready = 1'b1;
    tick(1);
    req_ready = 1'b0;
    check("occ_replace", cur(), pk(1'b1, 3'd4, 1'b0, 1'b0, 8'd1));
    tick(1);
    check("occ_replace_hold", cur(), pk(1'b1, 3'd4, 1'b0, 1'b0, 8'd1));
    set_btn(3'b000);
    tick(10);

    // Saturation: each triple press while full adds 3 drops.
    do_reset();
    sw = {3'd7, 3'd1};
    set_btn(3'b100);
    tick(7);
    set_btn(3'b000);
    tick(10);
    check("sat_pending", cur(), pk(1'b1, 3'd1, 1'b1, 1'b0, 8'd0));
    for (int i = 0; i < 100; i++) begin
      set_btn(3'b111);
      tick(7);
      set_btn(3'b000);
      tick(10);
      if (i == 0)  check("sat_plus3", {24'd0, drop_count}, 32'd3);
      if (i == 83) check("sat_252", {24'd0, drop_count}, 32'd252);
      if (i == 84) check("sat_255", {24'd0, drop_count}, 32'd255);
    end
    check("sat_final", cur(), pk(1'b1, 3'd1, 1'b1, 1'b0, 8'd255));

    // Asynchronous reset mid-debounce with a call pending; button held across release.
    sw = {3'd3, 3'd1};
    set_btn(3'b010);
    tick(3);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_clear", cur(), pk(1'b0, 3'd0, 1'b0, 1'b0, 8'd0));
    tick(2);
    reset = 1'b0;
    tick(6);
    check("post_reset_early", {31'd0, req_valid}, 32'd0);
    tick(1);
    check("post_reset_press", cur(), pk(1'b1, 3'd3, 1'b0, 1'b1, 8'd0));
    set_btn(3'b000);
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/call_request_conditioner.md
# call_request_conditioner

Front-end stage that turns the raw board buttons and floor switches into clean elevator call requests for `input_manager` and `controller`. It synchronises and debounces the three push buttons and detects each press as a single event. It captures the floor switches at the moment of the press and presents one call at a time over a valid/ready handshake. Invalid and overflowing presses are counted rather than silently lost.

## Interface
- `DEBOUNCE_CYCLES`, 20000: consecutive stable cycles required before a button level is accepted; must be ≥ 2.
- `DROP_W`, 8: width of the saturating drop counter.
- `clk` in 1: system clock, the clock-wizard output.
- `reset` in 1: asynchronous, active-high; clears all state.
- `button_up` in 1: raw hall-call-up button, asynchronous to `clk`.
- `button_down` in 1: raw hall-call-down button, asynchronous.
- `button_in` in 1: raw cabin-call button, asynchronous.
- `sw` in 6: `sw[5:3]` is the hall-call floor; `sw[2:0]` is the cabin destination floor. Both are quasi-static.
- `req_valid` out 1: a call is pending.
- `req_ready` in 1: the consumer accepts the call on an edge where `req_valid` and `req_ready` are both high.
- `req_floor` out 3: floor of the pending call.
- `req_in_out` out 1: 1 for a cabin call, 0 for a hall call.
- `req_dir` out 1: 1 for up, 0 for down. Don't-care when `req_in_out` is 1; it is driven 0.
- `drop_count` out `DROP_W`: saturating count of discarded presses.

## Operation
- Each button passes through a 2-FF synchroniser, then a debouncer.
- Debouncer state is `stable` plus a counter.
  - The counter increments on each cycle where the synchronised level differs from `stable`.
  - The counter clears on any cycle where they match, so bounce restarts the count.
  - When the counter reaches `DEBOUNCE_CYCLES-1` and the levels still differ, `stable` toggles and the counter clears.
- A press event is a rising edge of `stable`. Releases generate no event.
- Priority when several events occur on the same cycle: in > up > down. The winner is the only candidate; each other event increments `drop_count` by 1.
- Validity check on the candidate:
  - `button_up` with `sw[5:3]==7` is rejected.
  - `button_down` with `sw[5:3]==0` is rejected.
  - A rejected press increments `drop_count` and is not loaded.
- Payload captured at load, held unchanged while `req_valid` is high:
  - Cabin call: `req_floor=sw[2:0]`, `req_in_out=1`, `req_dir=0`.
  - Hall call: `req_floor=sw[5:3]`, `req_in_out=0`, `req_dir` per button.
- Single-entry holding register:
  - Idle (`req_valid=0`): a valid candidate loads and `req_valid` goes to 1.
  - Pending, no handshake this edge: a valid candidate is dropped and `drop_count` increments.
  - Handshake this edge, no candidate: `req_valid` goes to 0.
  - Handshake and valid candidate on the same edge: the new call loads and `req_valid` stays 1. Nothing is dropped.
- `drop_count` saturates at all-ones. All increments arising on one edge add together before saturation, up to +3.
- Reset values: `req_valid=0`, `req_floor=0`, `req_in_out=0`, `req_dir=0`, `drop_count=0`. All synchroniser flops, `stable` flags and counters are 0.
- Reset mid-operation discards any pending call. A button still held when reset releases is reported as a new press after the normal debounce latency.

## Timing
- Let edge N be the first edge at which a raw button is sampled high and stays high.
- `stable` rises after edge N+1+`DEBOUNCE_CYCLES`.
- `req_valid` rises after edge N+2+`DEBOUNCE_CYCLES`.
- `drop_count` updates on that same edge.
- Release-to-re-press: the next event needs the low level to be debounced first, taking `DEBOUNCE_CYCLES` cycles, then a fresh high.
- Throughput: one accepted call per cycle at most. Each button delivers at most one call per 2×`DEBOUNCE_CYCLES` cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `elevator_pkg` holds:
  - `FLOOR_W=3` and `TOP_FLOOR=7`.
  - Direction constants `DIR_UP=1'b1` and `DIR_DOWN=1'b0`.
  - `CALL_INSIDE=1'b1` and `CALL_HALL=1'b0`.
- Sub-module `button_debounce`, parameterised by `DEBOUNCE_CYCLES`:
  - Contains the synchroniser, counter and `stable` flag.
  - Outputs a one-cycle `press` pulse.
  - Instantiated three times.
- Arbitration, validity check, holding register and drop counter live in the top of this block.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.

1. Clean press: `button_in` high from edge 10, `sw[2:0]=5`, `req_ready=0` → `req_valid` rises after edge 16 with `req_floor=5`, `req_in_out=1`, and holds. Raising `req_ready` for one cycle clears it.
2. Bounce: `button_up` toggles 1,0,1,0 on successive cycles, then holds high → no event until 4 consecutive synchronised-high cycles. Exactly one request, `req_dir=1`.
3. Invalid hall calls:
   - `sw[5:3]=7` plus `button_up` → no `req_valid`, `drop_count=1`.
   - `sw[5:3]=0` plus `button_down` → `drop_count=2`.
4. Simultaneous presses: `button_in` and `button_down` raised on the same edge with `sw[5:3]=3` → cabin call is presented, `drop_count=1`.
5. Occupancy:
   - With a call pending and `req_ready=0`, a second press → dropped, `drop_count=1`, payload unchanged.
   - Repeat with `req_ready=1` on the load edge → new payload appears, `req_valid` stays 1, `drop_count` unchanged.
6. Saturation and reset:
   - Force 300 drops → `drop_count=255`.
   - Assert `reset` mid-debounce with a request pending → all outputs 0 immediately. A button held across reset release yields a request 6 edges after release.
